// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage load/store sequencer.
package mem_access_ctrl_pkg;

    localparam int WIDTH_MEM   = 32;
    localparam int TIMEOUT_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_LOAD,
        OP_STORE,
        OP_ILLEGAL
    } mem_op_t;

    // Classifies the instruction sitting in the MEM stage.
    function automatic mem_op_t decode_op(input logic valid, input logic rd, input logic wr);
        mem_op_t op;
        op = OP_NONE;
        if (valid) begin
            case ({rd, wr})
                2'b10:   op = OP_LOAD;
                2'b01:   op = OP_STORE;
                2'b11:   op = OP_ILLEGAL;
                default: op = OP_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_cnt.sv
// Clearable, enabled wait counter; flags terminal count at TIMEOUT-1 and saturates there.
module mem_timeout_cnt
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: drives a req/ack data memory, stalls the pipeline, bounds the wait.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_MEM,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_mem_rd,
    input  logic             i_mem_wr,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_mem_ack,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic [WIDTH-1:0] o_mem_wdata,
    output logic             o_sel_mem,
    output logic             o_reg_we,
    output logic             o_done,
    output logic             o_timeout,
    output logic             o_err,
    output logic             o_stall
);

    localparam int CW = $clog2(TIMEOUT);

    state_t           state;
    state_t           nxt_state;
    mem_op_t          op;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;

    logic             nxt_req;
    logic             nxt_we;
    logic [WIDTH-1:0] nxt_addr;
    logic [WIDTH-1:0] nxt_wdata;
    logic             nxt_sel;
    logic             nxt_reg_we;
    logic             nxt_done;
    logic             nxt_timeout;
    logic             nxt_err;

    assign op     = decode_op(i_valid, i_mem_rd, i_mem_wr);
    assign accept = (op == OP_LOAD) || (op == OP_STORE);

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Outputs are registered, so each DONE-cycle flag is computed on the edge entering DONE.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        nxt_state   = state;
        nxt_req     = o_mem_req;
        nxt_we      = o_mem_we;
        nxt_addr    = o_mem_addr;
        nxt_wdata   = o_mem_wdata;
        nxt_sel     = 1'b0;
        nxt_reg_we  = 1'b0;
        nxt_done    = 1'b0;
        nxt_timeout = 1'b0;
        nxt_err     = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    nxt_state = ST_ACCESS;
                    nxt_req   = 1'b1;
                    nxt_we    = (op == OP_STORE);
                    nxt_addr  = i_alu_out;
                    nxt_wdata = i_wr_data;
                    cnt_clr   = 1'b1;
                end else if (op == OP_ILLEGAL) begin
                    nxt_err = 1'b1;
                end
            end
            ST_ACCESS: begin
                // Ack is checked first so a late ack on the last cycle still completes.
                if (i_mem_ack) begin
                    nxt_state  = ST_DONE;
                    nxt_req    = 1'b0;
                    nxt_done   = 1'b1;
                    nxt_sel    = !o_mem_we;
                    nxt_reg_we = !o_mem_we;
                end else if (cnt_tc) begin
                    nxt_state   = ST_DONE;
                    nxt_req     = 1'b0;
                    nxt_done    = 1'b1;
                    nxt_timeout = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                nxt_state = ST_IDLE;
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_req   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: address/data holding registers are reset as well; every registered output reads 0 after reset.
        if (!i_rst_n) begin
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_sel_mem   <= 1'b0;
            o_reg_we    <= 1'b0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_mem_req   <= nxt_req;
            o_mem_we    <= nxt_we;
            o_mem_addr  <= nxt_addr;
            o_mem_wdata <= nxt_wdata;
            o_sel_mem   <= nxt_sel;
            o_reg_we    <= nxt_reg_we;
            o_done      <= nxt_done;
            o_timeout   <= nxt_timeout;
            o_err       <= nxt_err;
        end
    end

    // Stall drops in DONE so the pipeline advances on the completion cycle.
    assign o_stall = (state == ST_ACCESS) || ((state == ST_IDLE) && accept);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level timing model.
module tb_mem_access_ctrl;

    localparam int W  = 32;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         i_rst_n;
    logic         i_valid;
    logic         i_mem_rd;
    logic         i_mem_wr;
    logic [W-1:0] i_alu_out;
    logic [W-1:0] i_wr_data;
    logic         i_mem_ack;
    logic         o_mem_req;
    logic         o_mem_we;
    logic [W-1:0] o_mem_addr;
    logic [W-1:0] o_mem_wdata;
    logic         o_sel_mem;
    logic         o_reg_we;
    logic         o_done;
    logic         o_timeout;
    logic         o_err;
    logic         o_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_mem_rd    (i_mem_rd),
        .i_mem_wr    (i_mem_wr),
        .i_alu_out   (i_alu_out),
        .i_wr_data   (i_wr_data),
        .i_mem_ack   (i_mem_ack),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_sel_mem   (o_sel_mem),
        .o_reg_we    (o_reg_we),
        .o_done      (o_done),
        .o_timeout   (o_timeout),
        .o_err       (o_err),
        .o_stall     (o_stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid   = 1'b0;
        i_mem_rd  = 1'b0;
        i_mem_wr  = 1'b0;
        i_mem_ack = 1'b0;
    endtask

    // Packs every registered output so "all zero" is a single comparison.
    function automatic logic [2*W+6:0] all_regs();
        return {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_sel_mem,
                o_reg_we, o_done, o_timeout, o_err};
    endfunction

    // One load/store from the IDLE accept cycle through the cycle after DONE.
    // ack_at is the 1-based ACCESS cycle carrying ack; 0 or >TO means no ack in time.
    task automatic run_txn(input string tag, input bit is_load, input logic [W-1:0] addr,
                           input logic [W-1:0] data, input int ack_at);
        bit   exp_to;
        int   exp_n;
        bit   exp_rd;
        logic exp_we;
        int   req_cyc;
        int   stall_cyc;
        int   held_bad;
        int   done_cyc;
        bit   got_done;
        logic d_sel, d_reg_we, d_to, d_stall, d_req;

        exp_to = !(ack_at >= 1 && ack_at <= TO);
        exp_n  = exp_to ? TO : ack_at;
        exp_rd = is_load && !exp_to;
        exp_we = !is_load;

        req_cyc = 0; stall_cyc = 0; held_bad = 0; done_cyc = -1; got_done = 0;
        d_sel = 0; d_reg_we = 0; d_to = 0; d_stall = 0; d_req = 0;

        i_valid   = 1'b1;
        i_mem_rd  = is_load;
        i_mem_wr  = !is_load;
        i_alu_out = addr;
        i_wr_data = data;
        i_mem_ack = 1'b0;
        #1;
        if (o_stall) stall_cyc++;
        if (o_mem_req) req_cyc++;

        for (int cyc = 1; cyc <= TO + 4; cyc++) begin
            step();
            i_mem_ack = (cyc == ack_at);
            i_alu_out = $urandom();
            i_wr_data = $urandom();
            #1;
            if (o_done) begin
                got_done = 1; done_cyc = cyc;
                d_sel = o_sel_mem; d_reg_we = o_reg_we; d_to = o_timeout;
                d_stall = o_stall; d_req = o_mem_req;
                break;
            end
            if (o_stall) stall_cyc++;
            if (o_mem_req) begin
                req_cyc++;
                if (o_mem_addr !== addr || o_mem_we !== exp_we || o_mem_wdata !== data) held_bad++;
            end
        end

        total++;
        if (!got_done) begin
            bad++;
            $display("FAIL %s done_wait: no o_done within %0d cycles, expected at cycle %0d", tag, TO + 4, exp_n + 1);
            i_rst_n = 1'b0; idle_inputs(); step(); i_rst_n = 1'b1;
        end else begin
            total++;
            if (done_cyc !== exp_n + 1) begin
                bad++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_cyc, exp_n + 1);
            end
            total++;
            if (req_cyc !== exp_n) begin
                bad++; $display("FAIL %s req_cycles: got %0d expected %0d", tag, req_cyc, exp_n);
            end
            total++;
            if (stall_cyc !== exp_n + 1) begin
                bad++; $display("FAIL %s stall_cycles: got %0d expected %0d", tag, stall_cyc, exp_n + 1);
            end
            total++;
            if (held_bad !== 0) begin
                bad++; $display("FAIL %s held_fields: %0d unstable cycles expected 0 (addr=%h we=%b wdata=%h)",
                                tag, held_bad, addr, exp_we, data);
            end
            total++;
            if ({d_sel, d_reg_we, d_to} !== {exp_rd, exp_rd, exp_to}) begin
                bad++; $display("FAIL %s done_flags: sel/reg_we/timeout got %b%b%b expected %b%b%b",
                                tag, d_sel, d_reg_we, d_to, exp_rd, exp_rd, exp_to);
            end
            total++;
            if ({d_stall, d_req} !== 2'b00) begin
                bad++; $display("FAIL %s done_quiet: stall/req got %b%b expected 00", tag, d_stall, d_req);
            end
            step();
            idle_inputs();
            #1;
            total++;
            if ({o_done, o_timeout, o_reg_we, o_sel_mem, o_mem_req, o_err} !== 6'b0) begin
                bad++; $display("FAIL %s after_done: done/to/reg_we/sel/req/err got %b%b%b%b%b%b expected 000000",
                                tag, o_done, o_timeout, o_reg_we, o_sel_mem, o_mem_req, o_err);
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        idle_inputs();
        i_alu_out = 32'hFFFF_FFFF;
        i_wr_data = 32'hFFFF_FFFF;
        step();
        step();
        total++;
        if (all_regs() !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h expected 0", all_regs());
        end
        total++;
        if (o_stall !== 1'b0) begin
            bad++; $display("FAIL reset_stall: got %b expected 0", o_stall);
        end
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_ack3();
        run_txn("load_ack3", 1'b1, 32'h0000_0010, $urandom(), 3);
    endtask

    task automatic test_store_ack1();
        run_txn("store_ack1", 1'b0, 32'h0000_0024, 32'hDEAD_BEEF, 1);
    endtask

    task automatic test_load_timeout();
        run_txn("load_timeout", 1'b1, $urandom(), $urandom(), 0);
    endtask

    task automatic test_load_ack_last();
        run_txn("load_ack_last", 1'b1, $urandom(), $urandom(), TO);
    endtask

    task automatic test_reset_mid_access();
        i_valid = 1'b1; i_mem_rd = 1'b1; i_mem_wr = 1'b0;
        i_alu_out = 32'h1234_5678; i_wr_data = 32'h0BAD_F00D; i_mem_ack = 1'b0;
        step();
        #1;
        total++;
        if (o_mem_req !== 1'b1) begin
            bad++; $display("FAIL rst_mid req_before: got %b expected 1", o_mem_req);
        end
        step();
        i_rst_n = 1'b0;
        idle_inputs();
        step();
        total++;
        if (all_regs() !== '0 || o_stall !== 1'b0) begin
            bad++; $display("FAIL rst_mid outputs: regs=%h stall=%b expected 0", all_regs(), o_stall);
        end
        i_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if ({o_done, o_timeout, o_reg_we, o_mem_req} !== 4'b0) begin
                bad++; $display("FAIL rst_mid quiet_%0d: done/to/reg_we/req got %b%b%b%b expected 0000",
                                k, o_done, o_timeout, o_reg_we, o_mem_req);
            end
        end
        run_txn("rst_mid fresh_load", 1'b1, $urandom(), $urandom(), 2);
    endtask

    task automatic test_err_alu();
        i_valid = 1'b1; i_mem_rd = 1'b1; i_mem_wr = 1'b1; i_mem_ack = 1'b0;
        #1;
        total++;
        if (o_stall !== 1'b0) begin
            bad++; $display("FAIL err stall: got %b expected 0", o_stall);
        end
        step();
        idle_inputs();
        #1;
        total++;
        if ({o_err, o_mem_req} !== 2'b10) begin
            bad++; $display("FAIL err pulse: err/req got %b%b expected 10", o_err, o_mem_req);
        end
        step();
        total++;
        if ({o_err, o_mem_req, o_stall} !== 3'b000) begin
            bad++; $display("FAIL err after: err/req/stall got %b%b%b expected 000", o_err, o_mem_req, o_stall);
        end
        i_valid = 1'b1; i_mem_rd = 1'b0; i_mem_wr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_alu_out = $urandom();
            #1;
            total++;
            if (o_stall !== 1'b0) begin
                bad++; $display("FAIL alu_op stall_%0d: got %b expected 0", k, o_stall);
            end
            step();
            total++;
            if ({o_sel_mem, o_mem_req, o_done, o_err} !== 4'b0) begin
                bad++; $display("FAIL alu_op regs_%0d: sel/req/done/err got %b%b%b%b expected 0000",
                                k, o_sel_mem, o_mem_req, o_done, o_err);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        run_txn("b2b store", 1'b0, $urandom(), $urandom(), 2);
        run_txn("b2b load", 1'b1, $urandom(), $urandom(), 1);
        run_txn("b2b ack_in_done", 1'b1, $urandom(), $urandom(), TO + 1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                i_valid   = 1'($urandom_range(0, 1));
                i_mem_rd  = 1'b0;
                i_mem_wr  = 1'b0;
                i_mem_ack = 1'($urandom_range(0, 1));
                i_alu_out = $urandom();
                #1;
                total++;
                if ({o_stall, o_mem_req} !== 2'b00) begin
                    bad++; $display("FAIL rand_gap %0d.%0d: stall/req got %b%b expected 00", t, g, o_stall, o_mem_req);
                end
                step();
            end
            run_txn($sformatf("rand_%0d", t), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                    $urandom_range(0, TO + 2));
        end
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_alu_out = '0;
        i_wr_data = '0;
        idle_inputs();
        #2;
        test_reset();
        test_load_ack3();
        test_store_ack1();
        test_load_timeout();
        test_load_ack_last();
        test_reset_mid_access();
        test_err_alu();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
